// File: rtl/segment_transition_ctl_pkg.sv
// ============================================================================
// Module      : segment_transition_ctl_pkg
// Description : Shared types and constants for the segment transition control
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package segment_transition_ctl_pkg;

    localparam int          NUM_SEGMENT               = 2;
    localparam int unsigned TRANSITION_TIMEOUT_CYCLES = 2**24;
    localparam logic [15:0] REP_INFINITE              = 16'hFFFF;
    localparam logic [15:0] LOOP_CNT_MAX              = 16'hFFFE;

    typedef enum logic [7:0] {
        TRANSITION_MODE_SYNC_IDX = 8'h00,
        TRANSITION_MODE_SYS_TIME = 8'h01,
        TRANSITION_MODE_GPIO     = 8'h02,
        TRANSITION_MODE_EXT      = 8'hF0
    } transition_mode_t;

    typedef enum logic [2:0] {
        ST_PLAY          = 3'd0,
        ST_WAIT_IDX      = 3'd1,
        ST_WAIT_TIME     = 3'd2,
        ST_WAIT_GPIO     = 3'd3,
        ST_WAIT_EXT_LOOP = 3'd4
    } seg_ctl_state_t;

    function automatic logic is_valid_mode(input logic [7:0] mode);
        return (mode == TRANSITION_MODE_SYNC_IDX) ||
               (mode == TRANSITION_MODE_SYS_TIME) ||
               (mode == TRANSITION_MODE_GPIO)     ||
               (mode == TRANSITION_MODE_EXT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/segment_transition_ctl_if.sv
// ============================================================================
// Module      : segment_transition_ctl_if
// Description : Request/status bundle between register block, controller and
//               idx sampler. Adds TIMEOUT when SEG_TRANSITION_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface segment_transition_ctl_if;
    logic        update;
    logic        req_segment;
    logic [15:0] rep;
    logic [7:0]  mode;
    logic [63:0] value;
    logic [55:0] sys_time;
    logic [3:0]  gpio_in;
    logic        loop_pulse;
    logic        segment;
    logic        stop;
    logic        swapped;
    logic        busy;
    logic        err_mode;
`ifdef SEG_TRANSITION_TIMEOUT_EN
    logic        timeout;

    modport master (
        output update, req_segment, rep, mode, value, sys_time, gpio_in, loop_pulse,
        input  segment, stop, swapped, busy, err_mode, timeout
    );
    modport slave (
        input  update, req_segment, rep, mode, value, sys_time, gpio_in, loop_pulse,
        output segment, stop, swapped, busy, err_mode, timeout
    );
`else
    modport master (
        output update, req_segment, rep, mode, value, sys_time, gpio_in, loop_pulse,
        input  segment, stop, swapped, busy, err_mode
    );
    modport slave (
        input  update, req_segment, rep, mode, value, sys_time, gpio_in, loop_pulse,
        output segment, stop, swapped, busy, err_mode
    );
`endif
endinterface

`default_nettype wire

// File: rtl/segment_transition_ctl_seg_loop_counter.sv
// ============================================================================
// Module      : seg_loop_counter
// Description : Loop counter for the active segment with saturation and the
//               finite-repeat completion compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_loop_counter
    import segment_transition_ctl_pkg::*;
(
    input  wire        clk,
    input  wire        rst,
    input  wire        i_loop_pulse,
    input  wire        i_stop,
    input  wire        i_clear,
    input  wire [15:0] i_rep,
    output logic       o_done
);

    logic [15:0] r_loop_cnt;
    logic        w_count_en;

    assign w_count_en = i_loop_pulse & ~i_stop;
    // Compare uses the count before this pulse increments it, so REP=n means n+1 loops.
    assign o_done     = w_count_en && (i_rep != REP_INFINITE) && (r_loop_cnt == i_rep);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop_cnt <= 16'd0;
        end else if (i_clear) begin
            r_loop_cnt <= 16'd0;
        end else if (w_count_en && (r_loop_cnt != LOOP_CNT_MAX)) begin
            r_loop_cnt <= r_loop_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/segment_transition_ctl.sv
// ============================================================================
// Module      : segment_transition_ctl
// Description : Segment swap timing, finite repeat STOP and EXT ping-pong for
//               one double-buffered sequencer. Optional forced-swap timeout
//               enabled by SEG_TRANSITION_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_transition_ctl
    import segment_transition_ctl_pkg::*;
(
    input wire                       clk,
    input wire                       rst,
    segment_transition_ctl_if.slave  bus
);

    seg_ctl_state_t r_state, w_state_nxt;
    logic           r_segment, w_segment_nxt;
    logic           r_stop, w_stop_nxt;
    logic           r_swapped, w_swapped_nxt;
    logic           r_err_mode, w_err_mode_nxt;
    logic           r_req_seg, w_req_seg_nxt;
    logic [55:0]    r_value, w_value_nxt;
    logic [15:0]    r_rep_q [NUM_SEGMENT];
    logic [15:0]    w_rep_q_nxt [NUM_SEGMENT];
    logic [3:0]     r_gpio_prev;

    logic w_update_ok;
    logic w_gpio_rise;
    logic w_time_reached;
    logic w_waiting;
    logic w_trigger;
    logic w_cnt_clear;
    logic w_loop_done;
    logic w_timeout_hit;
    logic w_unused;

    assign w_unused       = &{1'b0, bus.value[63:56]};
    assign w_update_ok    = bus.update & is_valid_mode(bus.mode);
    assign w_gpio_rise    = bus.gpio_in[r_value[1:0]] & ~r_gpio_prev[r_value[1:0]];
    assign w_time_reached = (bus.sys_time >= r_value);
    assign w_waiting      = (r_state == ST_WAIT_IDX) || (r_state == ST_WAIT_TIME) ||
                            (r_state == ST_WAIT_GPIO);

    seg_loop_counter u_loop_counter (
        .clk          (clk),
        .rst          (rst),
        .i_loop_pulse (bus.loop_pulse),
        .i_stop       (r_stop),
        .i_clear      (w_cnt_clear),
        .i_rep        (r_rep_q[r_segment]),
        .o_done       (w_loop_done)
    );

`ifdef SEG_TRANSITION_TIMEOUT_EN
    logic [23:0] r_wait_cnt;
    logic        r_timeout;

    assign w_timeout_hit = w_waiting && (r_wait_cnt == 24'(TRANSITION_TIMEOUT_CYCLES - 1));
    assign bus.timeout   = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 24'd0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_waiting && !w_update_ok && !w_trigger) begin
                r_wait_cnt <= r_wait_cnt + 24'd1;
            end else begin
                r_wait_cnt <= 24'd0;
            end
            if (w_timeout_hit && !w_update_ok) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_segment_nxt  = r_segment;
        w_stop_nxt     = r_stop;
        w_swapped_nxt  = 1'b0;
        w_err_mode_nxt = r_err_mode | (bus.update & ~is_valid_mode(bus.mode));
        w_req_seg_nxt  = r_req_seg;
        w_value_nxt    = r_value;
        w_rep_q_nxt    = r_rep_q;
        w_trigger      = 1'b0;
        w_cnt_clear    = 1'b0;

        // A valid request preempts any trigger or repeat completion this cycle.
        if (w_update_ok) begin
            w_req_seg_nxt                   = bus.req_segment;
            w_rep_q_nxt[bus.req_segment]    = bus.rep;
            w_value_nxt                     = bus.value[55:0];
            case (bus.mode)
                TRANSITION_MODE_SYNC_IDX: w_state_nxt = ST_WAIT_IDX;
                TRANSITION_MODE_SYS_TIME: w_state_nxt = ST_WAIT_TIME;
                TRANSITION_MODE_GPIO:     w_state_nxt = ST_WAIT_GPIO;
                TRANSITION_MODE_EXT: begin
                    w_state_nxt   = ST_WAIT_EXT_LOOP;
                    w_segment_nxt = bus.req_segment;
                    w_swapped_nxt = 1'b1;
                    w_stop_nxt    = 1'b0;
                    w_cnt_clear   = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (r_state)
                ST_WAIT_IDX:  w_trigger = bus.loop_pulse | r_stop | w_timeout_hit;
                ST_WAIT_TIME: w_trigger = w_time_reached | w_timeout_hit;
                ST_WAIT_GPIO: w_trigger = w_gpio_rise | w_timeout_hit;
                ST_WAIT_EXT_LOOP: begin
                    if (w_loop_done) begin
                        w_segment_nxt = ~r_segment;
                        w_swapped_nxt = 1'b1;
                        w_stop_nxt    = 1'b0;
                        w_cnt_clear   = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_loop_done) begin
                        w_stop_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_PLAY;
            endcase

            if (w_trigger) begin
                w_state_nxt   = ST_PLAY;
                w_segment_nxt = r_req_seg;
                w_swapped_nxt = 1'b1;
                w_stop_nxt    = 1'b0;
                w_cnt_clear   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PLAY;
            r_segment   <= 1'b0;
            r_stop      <= 1'b0;
            r_swapped   <= 1'b0;
            r_err_mode  <= 1'b0;
            r_req_seg   <= 1'b0;
            r_value     <= 56'd0;
            r_rep_q     <= '{default: REP_INFINITE};
            r_gpio_prev <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_segment   <= w_segment_nxt;
            r_stop      <= w_stop_nxt;
            r_swapped   <= w_swapped_nxt;
            r_err_mode  <= w_err_mode_nxt;
            r_req_seg   <= w_req_seg_nxt;
            r_value     <= w_value_nxt;
            r_rep_q     <= w_rep_q_nxt;
            r_gpio_prev <= bus.gpio_in;
        end
    end

    assign bus.segment  = r_segment;
    assign bus.stop     = r_stop;
    assign bus.swapped  = r_swapped;
    assign bus.busy     = (r_state != ST_PLAY);
    assign bus.err_mode = r_err_mode;

endmodule

`default_nettype wire

// File: tb/tb_segment_transition_ctl.sv
// ============================================================================
// Module      : tb_segment_transition_ctl
// Description : Directed bench with a per-cycle reference model of the segment
//               transition rules plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_segment_transition_ctl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    segment_transition_ctl_if bus_if ();

    segment_transition_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_swapped_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending request kind 0=none 1=idx 2=time 3=gpio 4=ext
    bit          m_valid = 1'b0;
    bit          m_seg, m_stop, m_swapped, m_err, m_req;
    int          m_pend;
    int unsigned m_cnt;
    int unsigned m_rep [2];
    longint unsigned m_val;
    bit [3:0]    m_gprev;

    always @(posedge clk) begin : model
        bit upd_ok, counts, done, swap, tgt;
        int unsigned rep_act;
        if (rst) begin
            m_valid = 1'b1; m_seg = 0; m_stop = 0; m_swapped = 0; m_err = 0; m_req = 0;
            m_pend = 0; m_cnt = 0; m_rep[0] = 16'hFFFF; m_rep[1] = 16'hFFFF; m_val = 0; m_gprev = 0;
        end else if (m_valid) begin
            upd_ok  = bus_if.update && (bus_if.mode == 8'h00 || bus_if.mode == 8'h01 ||
                                        bus_if.mode == 8'h02 || bus_if.mode == 8'hF0);
            counts  = bus_if.loop_pulse && !m_stop;
            rep_act = m_rep[m_seg];
            done    = counts && (rep_act != 16'hFFFF) && (m_cnt == rep_act);
            swap    = 1'b0;
            tgt     = m_seg;
            if (bus_if.update && !upd_ok) m_err = 1'b1;
            if (upd_ok) begin
                m_req = bus_if.req_segment;
                m_rep[bus_if.req_segment] = bus_if.rep;
                m_val = {8'd0, bus_if.value[55:0]};
                case (bus_if.mode)
                    8'h00:   m_pend = 1;
                    8'h01:   m_pend = 2;
                    8'h02:   m_pend = 3;
                    default: begin m_pend = 4; swap = 1'b1; tgt = bus_if.req_segment; end
                endcase
            end else begin
                case (m_pend)
                    1: if (bus_if.loop_pulse || m_stop) begin swap = 1'b1; tgt = m_req; m_pend = 0; end
                    2: if (bus_if.sys_time >= m_val) begin swap = 1'b1; tgt = m_req; m_pend = 0; end
                    3: if (bus_if.gpio_in[m_val[1:0]] && !m_gprev[m_val[1:0]]) begin
                           swap = 1'b1; tgt = m_req; m_pend = 0;
                       end
                    4: if (done) begin swap = 1'b1; tgt = !m_seg; end
                    default: if (done) m_stop = 1'b1;
                endcase
            end
            if (swap) begin
                m_seg = tgt; m_stop = 1'b0; m_cnt = 0;
            end else if (counts && m_cnt < 16'hFFFE) begin
                m_cnt++;
            end
            m_swapped = swap;
            m_gprev   = bus_if.gpio_in;
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (m_valid) begin
            check("cycle {seg,stop,swapped,busy,err}",
                  {59'd0, bus_if.segment, bus_if.stop, bus_if.swapped, bus_if.busy, bus_if.err_mode},
                  {59'd0, m_seg, m_stop, m_swapped, (m_pend != 0), m_err});
        end
    end

    always @(negedge clk) if (bus_if.swapped === 1'b1) n_swapped_seen++;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        bus_if.loop_pulse = 1'b1;
        @(negedge clk);
        bus_if.loop_pulse = 1'b0;
    endtask

    task automatic upd(input bit seg, input logic [15:0] r, input logic [7:0] m, input logic [63:0] v);
        bus_if.req_segment = seg;
        bus_if.rep         = r;
        bus_if.mode        = m;
        bus_if.value       = v;
        bus_if.update      = 1'b1;
        @(negedge clk);
        bus_if.update      = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        bus_if.update = 0; bus_if.req_segment = 0; bus_if.rep = 0; bus_if.mode = 0;
        bus_if.value = 0; bus_if.sys_time = 0; bus_if.gpio_in = 0; bus_if.loop_pulse = 0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset segment", bus_if.segment, 0);
        check("reset stop", bus_if.stop, 0);
        check("reset busy", bus_if.busy, 0);
        check("reset err_mode", bus_if.err_mode, 0);

        // Pulses with no request change nothing
        repeat (5) begin pulse(); idle(1); end
        check("idle segment", bus_if.segment, 0);
        check("idle stop", bus_if.stop, 0);
        check("idle swapped count", n_swapped_seen, 0);

        // SYNC_IDX to seg1
        upd(1'b1, 16'hFFFF, 8'h00, 64'd0);
        check("idx busy pending", bus_if.busy, 1);
        idle(9);
        check("idx segment before pulse", bus_if.segment, 0);
        pulse();
        check("idx segment after pulse", bus_if.segment, 1);
        check("idx swapped pulse", bus_if.swapped, 1);
        idle(1);
        check("idx swapped cleared", bus_if.swapped, 0);
        check("idx busy cleared", bus_if.busy, 0);

        // Finite repeat: seg0 REP=2
        upd(1'b0, 16'd2, 8'h00, 64'd0);
        pulse();
        check("rep swap to seg0", bus_if.segment, 0);
        idle(1);
        pulse(); idle(1);
        pulse(); idle(1);
        check("rep stop after 2", bus_if.stop, 0);
        pulse();
        check("rep stop after 3", bus_if.stop, 1);
        idle(1);
        pulse();
        check("rep stop held", bus_if.stop, 1);
        check("rep segment held", bus_if.segment, 0);
        check("rep no swap", bus_if.swapped, 0);

        // SYS_TIME target 1000, ramp from 990
        bus_if.sys_time = 56'd990;
        upd(1'b1, 16'hFFFF, 8'h01, 64'd1000);
        for (int t = 991; t <= 1000; t++) begin
            bus_if.sys_time = 56'(t);
            @(negedge clk);
            if (t == 999) check("time before target", bus_if.segment, 0);
        end
        check("time segment", bus_if.segment, 1);
        check("time swapped", bus_if.swapped, 1);
        check("time stop cleared", bus_if.stop, 0);
        idle(1);
        check("time busy low", bus_if.busy, 0);

        // GPIO pin 2
        upd(1'b0, 16'hFFFF, 8'h02, 64'd2);
        bus_if.gpio_in = 4'b0010; idle(1);
        bus_if.gpio_in = 4'b0000; idle(1);
        bus_if.gpio_in = 4'b0010; idle(1);
        check("gpio wrong pin no swap", bus_if.segment, 1);
        check("gpio still busy", bus_if.busy, 1);
        bus_if.gpio_in = 4'b0110;
        @(negedge clk);
        check("gpio segment", bus_if.segment, 0);
        check("gpio swapped", bus_if.swapped, 1);
        bus_if.gpio_in = 4'b0000;
        idle(1);

        // EXT ping-pong with REP=1 on both segments
        upd(1'b0, 16'd1, 8'hF0, 64'd0);
        check("ext immediate swap", bus_if.swapped, 1);
        upd(1'b1, 16'd1, 8'hF0, 64'd0);
        check("ext seg1", bus_if.segment, 1);
        check("ext busy", bus_if.busy, 1);
        pulse(); idle(1);
        check("ext after 1 pulse", bus_if.segment, 1);
        pulse();
        check("ext after 2 pulses", bus_if.segment, 0);
        idle(1);
        pulse(); idle(1);
        pulse();
        check("ext after 4 pulses", bus_if.segment, 1);
        upd(1'b0, 16'd0, 8'h07, 64'd0);
        check("bad mode err", bus_if.err_mode, 1);
        check("bad mode segment kept", bus_if.segment, 1);
        pulse(); idle(1);
        pulse();
        check("ext continues after bad mode", bus_if.segment, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst segment", bus_if.segment, 0);
        check("rst err_mode", bus_if.err_mode, 0);
        check("rst busy", bus_if.busy, 0);

        // UPDATE coincident with a trigger wins; swap to active segment still pulses
        upd(1'b1, 16'hFFFF, 8'h00, 64'd0);
        bus_if.loop_pulse = 1'b1;
        upd(1'b0, 16'hFFFF, 8'h00, 64'd0);
        bus_if.loop_pulse = 1'b0;
        check("update beats trigger", bus_if.swapped, 0);
        pulse();
        check("same segment swap", bus_if.swapped, 1);
        check("same segment value", bus_if.segment, 0);

        // WAIT_IDX while STOP=1 swaps at once
        upd(1'b1, 16'd0, 8'h00, 64'd0);
        pulse();
        check("rep0 swap", bus_if.segment, 1);
        idle(1);
        pulse();
        check("rep0 stop", bus_if.stop, 1);
        upd(1'b0, 16'hFFFF, 8'h00, 64'd0);
        @(negedge clk);
        check("stop immediate swap", bus_if.segment, 0);
        check("stop immediate clear", bus_if.stop, 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
